l1ca_code_ctrl: RTL

//  Sequencer for one L1 C/A code generator channel. Latches SV, clears the generator, fast-seeks it to a

---
 rtl/l1ca_code_ctrl_pkg.sv | 30 +++
 rtl/l1ca_code_nco.sv | 37 +++
 rtl/l1ca_code_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/l1ca_code_ctrl_pkg.sv
// Shared types and constants for the L1 C/A code channel sequencer.
package l1ca_code_ctrl_pkg;

  localparam int unsigned CODE_ACC_W      = 32;
  localparam int unsigned CODE_SLEW_W     = 11;
  localparam int unsigned SV_W            = 5;
  localparam int unsigned CHIP_W          = 10;
  localparam int unsigned MS_W            = 5;
  localparam int unsigned L1CA_CODE_LEN   = 1023;
  localparam int unsigned L1CA_MS_PER_BIT = 20;

  typedef logic [SV_W-1:0]       sv_t;
  typedef logic [CHIP_W-1:0]     chip_t;
  typedef logic [CODE_ACC_W-1:0] code_rate_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SEEK,
    TRACK
  } code_ctrl_state_t;

  localparam chip_t LAST_CHIP = chip_t'(L1CA_CODE_LEN - 1);

  // Out-of-range start chips fold to chip 0.
  function automatic chip_t norm_chip(input chip_t c);
    return (32'(c) >= L1CA_CODE_LEN) ? '0 : c;
  endfunction

endpackage

// File: rtl/l1ca_code_nco.sv
// Code NCO: phase accumulator whose unsigned carry-out marks one chip.
module l1ca_code_nco #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             en,
  input  logic [ACC_W-1:0] rate,
  output logic             carry_c
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum_c;

  // Next accumulator value and carry; clear wins over enable.
  always_comb begin
    sum_c   = {1'b0, acc_q} + {1'b0, rate};
    carry_c = en & sum_c[ACC_W];
    acc_d   = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum_c[ACC_W-1:0];
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/l1ca_code_ctrl.sv
// L1 C/A code channel sequencer: clear, fast-seek, NCO-paced tracking with
// code-phase slews, code-epoch and 20 ms bit-boundary strobes.
// Optional early/prompt/late taps enabled by defining L1CA_EPL_EN.
module l1ca_code_ctrl
  import l1ca_code_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W  = CODE_ACC_W,
  parameter int unsigned SLEW_W = CODE_SLEW_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  sv_t               cmd_sv,
  input  chip_t             cmd_chip,
  input  logic [ACC_W-1:0]  cmd_rate,
  input  logic              stop,
  input  logic              slew_valid,
  output logic              slew_ready,
  input  logic [SLEW_W-1:0] slew_chips,
  output logic              gen_en,
  output logic              gen_clear,
  output sv_t               gen_sv,
  input  chip_t             gen_chip,
  input  logic              gen_code,
  output logic              prompt,
`ifdef L1CA_EPL_EN
  output logic              early,
  output logic              late,
`endif
  output logic              code_epoch,
  output logic [MS_W-1:0]   ms_count,
  output logic              bit_edge,
  output logic              tracking
);

  code_ctrl_state_t  state_q, state_d;
  sv_t               sv_q, sv_d;
  chip_t             target_q, target_d;
  logic [ACC_W-1:0]  rate_q, rate_d;
  logic [SLEW_W-1:0] slew_q, slew_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic              epoch_q, epoch_d;
  logic              bit_q, bit_d;

  logic cmd_xfer_c, slew_xfer_c, slew_pos_c, slew_neg_c;
  logic nco_clear_c, nco_en_c, carry_c, gen_en_c;

  // Handshakes; stop outranks a command, a command outranks a slew.
  assign cmd_ready   = (state_q == IDLE) | (state_q == TRACK);
  assign slew_ready  = (state_q == TRACK) & (slew_q == '0);
  assign cmd_xfer_c  = cmd_valid & cmd_ready & ~stop;
  assign slew_xfer_c = slew_valid & slew_ready & ~stop & ~cmd_xfer_c;
  assign slew_neg_c  = slew_q[SLEW_W-1];
  assign slew_pos_c  = ~slew_q[SLEW_W-1] & (slew_q != '0);

  l1ca_code_nco #(
    .ACC_W (ACC_W)
  ) u_nco (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (nco_clear_c),
    .en      (nco_en_c),
    .rate    (rate_q),
    .carry_c (carry_c)
  );

  // Sequencer next-state, generator pacing, slew and epoch bookkeeping.
  always_comb begin
    state_d     = state_q;
    sv_d        = sv_q;
    target_d    = target_q;
    rate_d      = rate_q;
    slew_d      = slew_q;
    ms_d        = ms_q;
    epoch_d     = 1'b0;
    bit_d       = 1'b0;
    nco_clear_c = 1'b0;
    nco_en_c    = 1'b0;
    gen_en_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_xfer_c) state_d = CLEAR;
      end
      CLEAR: begin
        nco_clear_c = 1'b1;
        ms_d        = '0;
        state_d     = (target_q == '0) ? TRACK : SEEK;
      end
      SEEK: begin
        // Leave on the step that lands on the target so seek to N costs N cycles.
        nco_clear_c = 1'b1;
        gen_en_c    = 1'b1;
        if (chip_t'(gen_chip + chip_t'(1)) == target_q) state_d = TRACK;
      end
      TRACK: begin
        nco_en_c = 1'b1;
        if (slew_pos_c) begin
          // At most one chip per cycle; a carry cycle spends no slew.
          gen_en_c = 1'b1;
          if (!carry_c) slew_d = slew_q - SLEW_W'(1);
        end else if (slew_neg_c) begin
          gen_en_c = 1'b0;
          if (carry_c) slew_d = slew_q + SLEW_W'(1);
        end else begin
          gen_en_c = carry_c;
        end
        epoch_d = gen_en_c & (gen_chip == LAST_CHIP);
        if (cmd_xfer_c) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase

    if (epoch_d) begin
      bit_d = (ms_q == MS_W'(L1CA_MS_PER_BIT - 1));
      ms_d  = bit_d ? '0 : ms_q + MS_W'(1);
    end

    if (slew_xfer_c) slew_d = slew_chips;

    if (cmd_xfer_c) begin
      sv_d     = cmd_sv;
      target_d = norm_chip(cmd_chip);
      rate_d   = cmd_rate;
      slew_d   = '0;
    end

    if (stop) begin
      state_d = IDLE;
      slew_d  = '0;
    end
  end

  // Sequencer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      sv_q     <= '0;
      target_q <= '0;
      rate_q   <= '0;
      slew_q   <= '0;
      ms_q     <= '0;
      epoch_q  <= 1'b0;
      bit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sv_q     <= sv_d;
      target_q <= target_d;
      rate_q   <= rate_d;
      slew_q   <= slew_d;
      ms_q     <= ms_d;
      epoch_q  <= epoch_d;
      bit_q    <= bit_d;
    end
  end

  assign gen_en     = gen_en_c;
  assign gen_clear  = (state_q == CLEAR);
  assign gen_sv     = sv_q;
  assign tracking   = (state_q == TRACK);
  assign code_epoch = epoch_q;
  assign bit_edge   = bit_q;
  assign ms_count   = ms_q;

`ifdef L1CA_EPL_EN
  logic [2:0] taps_q, taps_d;

  // Early/prompt/late shift on every generator step, zeroed with the generator.
  always_comb begin
    taps_d = taps_q;
    if (state_q == CLEAR) begin
      taps_d = '0;
    end else if (gen_en_c) begin
      taps_d = {taps_q[1:0], gen_code};
    end
  end

  // Tap register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign early  = taps_q[0];
  assign prompt = taps_q[1];
  assign late   = taps_q[2];
`else
  assign prompt = gen_code;
`endif

endmodule
